voter3_ft_monitor: RTL
======================

// Module: voter3_ft_monitor
// PURPOSE
//  Registered, parametrised TMR voter with per-field majority and per-replica health tracking.
//  Votes WIDTH-bit words from three redundant cv32e40p pipeline copies.
//  Counts replica errors and excludes a persistently faulty replica, degrading TMR -> DMR -> FAIL.
//  Sits at replicated-stage outputs; feeds the fault-status CSR/reporting logic.
// PARAMETERS
//  WIDTH      32  voted word width
//  FIELDS     1   independent vote fields; WIDTH % FIELDS == 0, field f = bits [f*WIDTH/FIELDS +: WIDTH/FIELDS]
//  ERR_CNT_W  8   width of saturating per-replica error counters
//  EXCLUDE_TH 4   consecutive flagged votes (>=1) that exclude a replica in TMR mode
// PORTS
//  clk_i           in   1          clock
//  rst_i           in   1          synchronous active-high reset
//  in_1_i          in   WIDTH      replica 1 data
//  in_2_i          in   WIDTH      replica 2 data
//  in_3_i          in   WIDTH      replica 3 data
//  valid_i         in   1          inputs valid this cycle; vote and update only when high
//  clear_i         in   1          clear counters/streaks, return to TMR, re-include all replicas
//  voted_o         out  WIDTH      voted word (registered)
//  valid_o         out  1          valid_i delayed 1 cycle
//  err_detected_o  out  3          bit k-1 = replica k disagreed in >=1 field (registered, per vote)
//  err_corrected_o out  1          >=1 disagreement, all fields resolved by majority
//  err_uncorr_o    out  1          disagreement not resolvable (all-differ field, DMR mismatch, FAIL)
//  mode_o          out  2          2'b00 TMR, 2'b01 DMR, 2'b10 FAIL
//  excluded_o      out  3          one-hot excluded replica; 3'b000 = none
//  err_cnt_o       out  3*ERR_CNT_W  packed [2:0][ERR_CNT_W-1:0] total flagged votes per replica
// BEHAVIOUR
//  - Reset: voted_o=0, valid_o=0, err_*_o=0, mode_o=TMR, excluded_o=0, err_cnt_o=0, streaks=0.
//  - Latency 1: outputs on cycle N+1 reflect inputs and mode/state at cycle N.
//  - valid_i=0: valid_o=0, err flags=0, voted_o holds, no state change (clear_i still acts).
//  - TMR, per field: two or three equal -> majority; dissenting replica flagged.
//    All three differ -> field = in_1_i, all three flagged, err_uncorr_o=1.
//  - err_corrected_o = any flag & ~err_uncorr_o. Flags/corrected/uncorr are single-cycle, non-sticky.
//  - Streak per replica (TMR only): +1 on valid vote where flagged and no all-differ field;
//    cleared to 0 when replica agrees on a valid vote; unchanged on all-differ votes.
//  - Streak reaching EXCLUDE_TH: next state DMR, excluded_o = that replica.
//    Simultaneous threshold: exclude lowest index.
//  - DMR: compare the two remaining replicas word-wide; equal -> pass through.
//    Mismatch -> voted_o = lower-index remaining, both flagged, err_uncorr_o=1, next state FAIL.
//  - FAIL: voted_o = lowest-index non-excluded replica.
//    err_uncorr_o=1 on every valid vote; flags raised for any replica differing from output.
//  - DMR/FAIL leave only via clear_i or rst_i; excluded replica never flagged and its counter frozen.
//  - err_cnt: +1 per valid vote where replica flagged; saturates at 2**ERR_CNT_W-1, no wrap.
//  - clear_i with valid_i: vote uses current mode and is output normally.
//    Clear wins over all counter/streak/mode updates; next cycle TMR, counters 0.
//  - rst_i mid-stream: in-flight vote dropped (valid_o=0 next cycle), full reset state.
// TESTING
//  1. Equal inputs 0xDEADBEEF, valid_i=1 -> next cycle voted_o=0xDEADBEEF, valid_o=1, all flags 0, mode TMR.
//  2. in_2 differs once (0x1 vs 0x0) -> voted_o=0x0, err_detected_o=3'b010, err_corrected_o=1, err_cnt[1]=1.
//     Agree next vote -> streak cleared.
//  3. EXCLUDE_TH=4, in_3 wrong 4 consecutive valid votes -> mode_o=DMR, excluded_o=3'b100 after 4th vote.
//     Then in_1!=in_2 -> err_uncorr_o=1, voted_o=in_1, mode FAIL.
//  4. FIELDS=4, in_1 wrong byte0, in_2 wrong byte3 -> each byte majority-corrected, err_detected_o=3'b011.
//     err_corrected_o=1, err_uncorr_o=0.
//  5. All differ (1,2,3) -> voted_o=1, err_detected_o=3'b111, err_uncorr_o=1, mode stays TMR, streaks unchanged.
//  6. ERR_CNT_W=2, 5 flagged votes -> err_cnt saturates at 3.
//     clear_i with valid_i -> vote output, next cycle counters 0, mode TMR.

Source files
------------

// File: rtl/voter3_ft_monitor_if.sv
// Data/status bundle for the TMR voter: three replica words in,
// the voted word plus fault-status out.
interface voter3_ft_monitor_if #(
    parameter int WIDTH     = 32,
    parameter int ERR_CNT_W = 8
);
    logic [WIDTH-1:0]              in_1_i;
    logic [WIDTH-1:0]              in_2_i;
    logic [WIDTH-1:0]              in_3_i;
    logic                          valid_i;
    logic                          clear_i;
    logic [WIDTH-1:0]              voted_o;
    logic                          valid_o;
    logic [2:0]                    err_detected_o;
    logic                          err_corrected_o;
    logic                          err_uncorr_o;
    logic [1:0]                    mode_o;
    logic [2:0]                    excluded_o;
    logic [2:0][ERR_CNT_W-1:0]     err_cnt_o;

    modport master (
        output in_1_i, in_2_i, in_3_i, valid_i, clear_i,
        input  voted_o, valid_o, err_detected_o, err_corrected_o, err_uncorr_o,
               mode_o, excluded_o, err_cnt_o
    );

    modport slave (
        input  in_1_i, in_2_i, in_3_i, valid_i, clear_i,
        output voted_o, valid_o, err_detected_o, err_corrected_o, err_uncorr_o,
               mode_o, excluded_o, err_cnt_o
    );
endinterface

// File: rtl/voter3_ft_monitor.sv
// Registered TMR voter with per-field majority, per-replica error counters
// and streak-based exclusion that degrades TMR -> DMR -> FAIL.
module voter3_field #(
    parameter int FW = 32
) (
    input  logic [FW-1:0] a,
    input  logic [FW-1:0] b,
    input  logic [FW-1:0] c,
    output logic [FW-1:0] v,
    output logic [2:0]    flag,
    output logic          all_diff
);
    always_comb begin
        v        = a;
        flag     = 3'b000;
        all_diff = 1'b0;
        if (a == b) begin
            if (a != c) flag = 3'b100;
        end else if (a == c) begin
            flag = 3'b010;
        end else if (b == c) begin
            v    = b;
            flag = 3'b001;
        end else begin
            flag     = 3'b111;
            all_diff = 1'b1;
        end
    end
endmodule

module voter3_ft_monitor #(
    parameter int WIDTH      = 32,
    parameter int FIELDS     = 1,
    parameter int ERR_CNT_W  = 8,
    parameter int EXCLUDE_TH = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    voter3_ft_monitor_if.slave  bus
);
    localparam int FW = WIDTH / FIELDS;
    localparam int SW = $clog2(EXCLUDE_TH + 1);
    localparam logic [SW-1:0]        TH_V    = SW'(EXCLUDE_TH);
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {TMR = 2'b00, DMR = 2'b01, FAIL = 2'b10} mode_t;

    mode_t                      state_q, state_d;
    logic [2:0]                 excl_q, excl_d;
    logic [2:0][SW-1:0]         streak_q, streak_d;
    logic [2:0][ERR_CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]                 vld_pipe;

    logic [WIDTH-1:0]           voted_q;
    logic [2:0]                 det_q;
    logic                       corr_q, unc_q;

    logic [FIELDS-1:0][2:0]     fld_flag;
    logic [FIELDS-1:0]          fld_ad;
    logic [WIDTH-1:0]           tmr_word;
    logic [2:0]                 tmr_flag;

    logic [WIDTH-1:0]           lo_word, hi_word, vote_word;
    logic [2:0]                 lo_bit, hi_bit, vote_flag;
    logic                       vote_unc;

    assign vld_pipe[0] = bus.valid_i;

    for (genvar f = 0; f < FIELDS; f++) begin : g_fld
        voter3_field #(.FW(FW)) u_fld (
            .a        (bus.in_1_i[f*FW +: FW]),
            .b        (bus.in_2_i[f*FW +: FW]),
            .c        (bus.in_3_i[f*FW +: FW]),
            .v        (tmr_word[f*FW +: FW]),
            .flag     (fld_flag[f]),
            .all_diff (fld_ad[f])
        );
    end

    always_comb begin
        tmr_flag = 3'b000;
        for (int f = 0; f < FIELDS; f++) tmr_flag = tmr_flag | fld_flag[f];
    end

    // The two surviving replicas once one has been excluded, lower index first.
    always_comb begin
        lo_word = bus.in_1_i;
        hi_word = bus.in_2_i;
        lo_bit  = 3'b001;
        hi_bit  = 3'b010;
        case (excl_q)
            3'b001: begin
                lo_word = bus.in_2_i; hi_word = bus.in_3_i;
                lo_bit  = 3'b010;     hi_bit  = 3'b100;
            end
            3'b010: begin
                hi_word = bus.in_3_i;
                hi_bit  = 3'b100;
            end
            default: ;
        endcase
    end

    always_comb begin
        vote_word = lo_word;
        vote_flag = 3'b000;
        vote_unc  = 1'b0;
        state_d   = state_q;
        excl_d    = excl_q;
        streak_d  = streak_q;
        cnt_d     = cnt_q;

        case (state_q)
            TMR: begin
                vote_word = tmr_word;
                vote_flag = tmr_flag;
                vote_unc  = |fld_ad;
            end
            DMR: begin
                if (lo_word != hi_word) begin
                    vote_flag = lo_bit | hi_bit;
                    vote_unc  = 1'b1;
                end
            end
            default: begin
                vote_unc = 1'b1;
                if (hi_word != lo_word) vote_flag = hi_bit;
            end
        endcase

        if (bus.valid_i) begin
            for (int k = 0; k < 3; k++)
                if (vote_flag[k] && cnt_q[k] != CNT_MAX) cnt_d[k] = cnt_q[k] + ERR_CNT_W'(1);

            // All-differ votes say nothing about which replica is bad: leave streaks alone.
            if (state_q == TMR && !vote_unc) begin
                for (int k = 0; k < 3; k++)
                    streak_d[k] = vote_flag[k] ? streak_q[k] + SW'(1) : '0;
                if (streak_d[0] >= TH_V) begin
                    state_d = DMR; excl_d = 3'b001;
                end else if (streak_d[1] >= TH_V) begin
                    state_d = DMR; excl_d = 3'b010;
                end else if (streak_d[2] >= TH_V) begin
                    state_d = DMR; excl_d = 3'b100;
                end
            end

            if (state_q == DMR && vote_unc) state_d = FAIL;
        end

        if (bus.clear_i) begin
            state_d  = TMR;
            excl_d   = 3'b000;
            streak_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= TMR;
            excl_q      <= 3'b000;
            streak_q    <= '0;
            cnt_q       <= '0;
            vld_pipe[1] <= 1'b0;
            voted_q     <= '0;
            det_q       <= 3'b000;
            corr_q      <= 1'b0;
            unc_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            excl_q      <= excl_d;
            streak_q    <= streak_d;
            cnt_q       <= cnt_d;
            vld_pipe[1] <= vld_pipe[0];
            if (vld_pipe[0]) begin
                voted_q <= vote_word;
                det_q   <= vote_flag;
                corr_q  <= (|vote_flag) & ~vote_unc;
                unc_q   <= vote_unc;
            end else begin
                det_q   <= 3'b000;
                corr_q  <= 1'b0;
                unc_q   <= 1'b0;
            end
        end
    end

    assign bus.voted_o         = voted_q;
    assign bus.valid_o         = vld_pipe[1];
    assign bus.err_detected_o  = det_q;
    assign bus.err_corrected_o = corr_q;
    assign bus.err_uncorr_o    = unc_q;
    assign bus.mode_o          = state_q;
    assign bus.excluded_o      = excl_q;
    assign bus.err_cnt_o       = cnt_q;
endmodule
